// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - MIPS instruction fetch and program-counter stage
//
// Holds the PC, fetches one instruction at a time from instruction memory
// over a req/ack handshake, presents it for execute, then advances the PC
// using the decoder's branch/jump outputs and the ALU zero flag.
//
// Parameters:
//   PC_RESET  PC value loaded on reset (word aligned)
//   MAX_WAIT  imem wait cycles allowed before the fetch is declared failed (1..255)
//
// Ports:
//   i_clk          clock, all state updates on rising edge
//   i_reset        synchronous active-low reset
//   o_imem_req     fetch request to instruction memory
//   o_imem_addr    fetch address (equals o_pc)
//   i_imem_ack     imem_rdata is valid this cycle
//   i_imem_rdata   instruction word
//   o_instr        registered current instruction
//   o_op           o_instr[31:26], to the control decoder
//   o_instr_valid  high during the execute cycle(s) of o_instr
//   o_pc           address of the current instruction
//   o_pc_plus4     o_pc + 4, for JAL link and branch base
//   i_branch_eq    BranchEQ from the control decoder
//   i_branch_ne    BranchNE from the control decoder
//   i_jump         Jump from the control decoder
//   i_zero         ALU zero flag
//   i_stall        hold in execute, no PC update
//   o_fetch_err    sticky: imem did not ack within MAX_WAIT cycles

module fetch_unit #(
    parameter logic [31:0] PC_RESET = 32'h0040_0000,
    parameter int          MAX_WAIT = 15
) (
    input  logic        i_clk,
    input  logic        i_reset,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_instr,
    output logic [5:0]  o_op,
    output logic        o_instr_valid,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4,
    input  logic        i_branch_eq,
    input  logic        i_branch_ne,
    input  logic        i_jump,
    input  logic        i_zero,
    input  logic        i_stall,
    output logic        o_fetch_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    // Counter value seen during the last permitted FETCH cycle; a miss there
    // means MAX_WAIT cycles have gone by without an ack.
    localparam logic [7:0] LP_WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic        r_instr_valid;
    logic        r_imem_req;
    logic        r_fetch_err;
    logic [7:0]  r_wait_cnt;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_jump_target;
    logic [31:0] w_branch_off;
    logic [31:0] w_branch_target;
    logic        w_take_branch;
    logic [31:0] w_next_pc;

    // Next-PC selection; all arithmetic wraps modulo 2^32.
    assign w_pc_plus4      = r_pc + 32'd4;
    assign w_jump_target   = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};
    assign w_branch_off    = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
    assign w_branch_target = w_pc_plus4 + w_branch_off;
    assign w_take_branch   = (i_branch_eq & i_zero) | (i_branch_ne & ~i_zero);
    assign w_next_pc       = i_jump        ? w_jump_target   :
                             w_take_branch ? w_branch_target :
                                             w_pc_plus4;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state       <= S_IDLE;
            r_pc          <= PC_RESET;
            r_instr       <= 32'd0;
            r_instr_valid <= 1'b0;
            r_imem_req    <= 1'b0;
            r_fetch_err   <= 1'b0;
            r_wait_cnt    <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state    <= S_FETCH;
                    r_imem_req <= 1'b1;
                end
                S_FETCH: begin
                    if (i_imem_ack) begin
                        r_instr       <= i_imem_rdata;
                        r_wait_cnt    <= 8'd0;
                        r_imem_req    <= 1'b0;
                        r_instr_valid <= 1'b1;
                        r_state       <= S_EXEC;
                    end else if (r_wait_cnt == LP_WAIT_LAST) begin
                        r_fetch_err <= 1'b1;
                        r_imem_req  <= 1'b0;
                        r_state     <= S_HALT;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                S_EXEC: begin
                    // Branch/jump inputs matter only on the edge leaving EXEC.
                    if (!i_stall) begin
                        r_pc          <= w_next_pc;
                        r_instr_valid <= 1'b0;
                        r_imem_req    <= 1'b1;
                        r_state       <= S_FETCH;
                    end
                end
                S_HALT: begin
                    r_imem_req    <= 1'b0;
                    r_instr_valid <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_imem_req    = r_imem_req;
    assign o_imem_addr   = r_pc;
    assign o_instr       = r_instr;
    assign o_op          = r_instr[31:26];
    assign o_instr_valid = r_instr_valid;
    assign o_pc          = r_pc;
    assign o_pc_plus4    = w_pc_plus4;
    assign o_fetch_err   = r_fetch_err;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit

module tb_fetch_unit;

    localparam logic [31:0] ADDI   = 32'h2008_0005;
    localparam logic [31:0] BEQ_M4 = 32'h1000_FFFC;
    localparam logic [31:0] J_10   = 32'h0810_0004;
    localparam logic [31:0] J_20   = 32'h0810_0008;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        branch_eq, branch_ne, jump, zero, stall;

    logic        imem_req,   w_imem_req;
    logic [31:0] imem_addr,  w_imem_addr;
    logic [31:0] instr,      w_instr;
    logic [5:0]  op,         w_op;
    logic        instr_valid, w_instr_valid;
    logic [31:0] pc,         w_pc;
    logic [31:0] pc_plus4,   w_pc_plus4;
    logic        fetch_err,  w_fetch_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .i_clk(clk), .i_reset(rst_n),
        .o_imem_req(imem_req), .o_imem_addr(imem_addr),
        .i_imem_ack(imem_ack), .i_imem_rdata(imem_rdata),
        .o_instr(instr), .o_op(op), .o_instr_valid(instr_valid),
        .o_pc(pc), .o_pc_plus4(pc_plus4),
        .i_branch_eq(branch_eq), .i_branch_ne(branch_ne), .i_jump(jump),
        .i_zero(zero), .i_stall(stall), .o_fetch_err(fetch_err)
    );

    fetch_unit #(.PC_RESET(32'hFFFF_FFFC)) dut_w (
        .i_clk(clk), .i_reset(rst_n),
        .o_imem_req(w_imem_req), .o_imem_addr(w_imem_addr),
        .i_imem_ack(imem_ack), .i_imem_rdata(imem_rdata),
        .o_instr(w_instr), .o_op(w_op), .o_instr_valid(w_instr_valid),
        .o_pc(w_pc), .o_pc_plus4(w_pc_plus4),
        .i_branch_eq(branch_eq), .i_branch_ne(branch_ne), .i_jump(jump),
        .i_zero(zero), .i_stall(stall), .o_fetch_err(w_fetch_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // From a FETCH cycle: zero-wait ack of word w, then one EXEC cycle with
    // the given decoder/ALU inputs. Returns in the following FETCH cycle.
    task automatic fetch_exec(input logic [31:0] w, input logic beq, input logic bne,
                              input logic j, input logic z);
        imem_ack = 1'b1; imem_rdata = w;
        tick();
        imem_ack = 1'b0; imem_rdata = 32'hDEAD_BEEF;
        branch_eq = beq; branch_ne = bne; jump = j; zero = z;
        tick();
        branch_eq = 1'b0; branch_ne = 1'b0; jump = 1'b0; zero = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = 32'd0;
        branch_eq = 1'b0; branch_ne = 1'b0; jump = 1'b0; zero = 1'b0; stall = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_pc", pc, 32'h0040_0000);
        chk("rst_err", {31'd0, fetch_err}, 32'd0);
        chk("rst_pc_w", w_pc, 32'hFFFF_FFFC);

        // Sequential run: IDLE then first request
        rst_n = 1'b1;
        tick();
        chk("seq_req0", {31'd0, imem_req}, 32'd1);
        chk("seq_addr0", imem_addr, 32'h0040_0000);
        chk("seq_pc4", pc_plus4, 32'h0040_0004);
        imem_ack = 1'b1; imem_rdata = ADDI;
        tick();
        imem_ack = 1'b0;
        chk("seq_valid0", {31'd0, instr_valid}, 32'd1);
        chk("seq_req_exec", {31'd0, imem_req}, 32'd0);
        chk("seq_op", {26'd0, op}, 32'h08);
        chk("seq_instr", instr, ADDI);
        tick();
        chk("seq_valid1", {31'd0, instr_valid}, 32'd0);
        chk("seq_addr1", imem_addr, 32'h0040_0004);
        chk("wrap_addr1", w_imem_addr, 32'h0000_0000);
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        chk("seq_valid2", {31'd0, instr_valid}, 32'd1);
        tick();
        chk("seq_addr2", imem_addr, 32'h0040_0008);

        // Walk to 0x00400010
        fetch_exec(ADDI, 1'b0, 1'b0, 1'b0, 1'b0);
        fetch_exec(ADDI, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("br_start", pc, 32'h0040_0010);

        // BEQ taken / not taken, then BNE taken / not taken
        fetch_exec(BEQ_M4, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("beq_taken", pc, 32'h0040_0004);
        fetch_exec(J_10, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("jmp_back1", pc, 32'h0040_0010);
        fetch_exec(BEQ_M4, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("beq_not", pc, 32'h0040_0014);
        fetch_exec(J_10, 1'b0, 1'b0, 1'b1, 1'b0);
        fetch_exec(BEQ_M4, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("bne_taken", pc, 32'h0040_0004);
        fetch_exec(J_10, 1'b0, 1'b0, 1'b1, 1'b0);
        fetch_exec(BEQ_M4, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("bne_not", pc, 32'h0040_0014);

        // Jump has priority over a taken branch
        fetch_exec(J_20, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("jmp_prio", pc, 32'h0040_0020);

        // Wait states with decoder noise during FETCH, then 2-cycle stall
        jump = 1'b1; branch_eq = 1'b1; zero = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wait_addr", imem_addr, 32'h0040_0020);
            chk("wait_req", {31'd0, imem_req}, 32'd1);
        end
        jump = 1'b0; branch_eq = 1'b0; zero = 1'b0;
        imem_ack = 1'b1; imem_rdata = ADDI;
        tick();
        chk("wait_valid", {31'd0, instr_valid}, 32'd1);
        stall = 1'b1; imem_rdata = 32'h1234_5678;
        tick();
        chk("stall_valid1", {31'd0, instr_valid}, 32'd1);
        chk("stall_pc1", pc, 32'h0040_0020);
        chk("stall_instr", instr, ADDI);
        imem_ack = 1'b0;
        tick();
        chk("stall_valid2", {31'd0, instr_valid}, 32'd1);
        chk("stall_pc2", pc, 32'h0040_0020);
        stall = 1'b0;
        tick();
        chk("stall_pc_once", pc, 32'h0040_0024);
        chk("stall_refetch", {31'd0, imem_req}, 32'd1);

        // Timeout: 15 FETCH cycles without ack
        for (int i = 0; i < 14; i++) tick();
        chk("to_err_early", {31'd0, fetch_err}, 32'd0);
        chk("to_req_early", {31'd0, imem_req}, 32'd1);
        tick();
        chk("to_err", {31'd0, fetch_err}, 32'd1);
        chk("to_req", {31'd0, imem_req}, 32'd0);
        chk("to_pc", pc, 32'h0040_0024);
        imem_ack = 1'b1; imem_rdata = ADDI;
        tick(); tick();
        imem_ack = 1'b0;
        chk("halt_err", {31'd0, fetch_err}, 32'd1);
        chk("halt_req", {31'd0, imem_req}, 32'd0);
        chk("halt_valid", {31'd0, instr_valid}, 32'd0);
        chk("halt_pc", pc, 32'h0040_0024);

        // Reset from HALT
        rst_n = 1'b0;
        tick();
        chk("rh_err", {31'd0, fetch_err}, 32'd0);
        chk("rh_pc", pc, 32'h0040_0000);
        rst_n = 1'b1;
        tick();
        chk("rh_req", {31'd0, imem_req}, 32'd1);
        chk("rh_addr", imem_addr, 32'h0040_0000);

        // Move off PC_RESET, then reset mid-handshake with ack in that cycle
        fetch_exec(ADDI, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("mid_pre_pc", pc, 32'h0040_0004);
        rst_n = 1'b0; imem_ack = 1'b1; imem_rdata = ADDI;
        tick();
        rst_n = 1'b1; imem_ack = 1'b0;
        chk("mid_instr", instr, 32'd0);
        chk("mid_valid", {31'd0, instr_valid}, 32'd0);
        chk("mid_pc", pc, 32'h0040_0000);
        chk("mid_req", {31'd0, imem_req}, 32'd0);
        tick();
        chk("mid_restart", {31'd0, imem_req}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
